// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: tracks in-flight register writers, detects
// load-use hazards, and arbitrates stalls, flushes and memory freezes.
module hazard_ctrl_unit #(
    parameter int CORE         = 0,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    id_valid,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic [4:0]              id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,

    input  logic                    ex_branch_taken,
    input  logic [ADDRESS_BITS-1:0] ex_branch_target,
    input  logic                    mem_busy,

    output logic                    stall_if_id,
    output logic                    freeze_all,
    output logic                    bubble_id_ex,
    output logic                    flush_if_id,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic [31:0]             stall_count,
    output logic [31:0]             flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_is_load;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_is_load;

    logic rs1_match;
    logic rs2_match;
    logic load_use;
    logic id_writes;

    // x0 is hardwired to zero, so a matching source of x0 never depends on a load.
    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd) && (id_rs1 != 5'd0);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd) && (id_rs2 != 5'd0);
    assign load_use  = ex_valid && ex_is_load && id_valid && (rs1_match || rs2_match);
    assign id_writes = id_valid && id_reg_write && (id_rd != 5'd0) && !bubble_id_ex;

    always_comb begin
        next_state = RUN;
        if (mem_busy) begin
            next_state = MEM_WAIT;
        end else if (ex_branch_taken) begin
            next_state = FLUSH;
        end else if (load_use) begin
            next_state = LOAD_STALL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        stall_if_id    = 1'b0;
        freeze_all     = 1'b0;
        bubble_id_ex   = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_PC    = '0;
        if (!reset) begin
            if (mem_busy) begin
                freeze_all = 1'b1;
            end else if (ex_branch_taken) begin
                redirect_valid = 1'b1;
                redirect_PC    = ex_branch_target;
                flush_if_id    = 1'b1;
                bubble_id_ex   = 1'b1;
            end else if (load_use) begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Scoreboard shifts one stage per edge unless memory holds the whole pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= 5'd0;
            ex_is_load  <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rd      <= 5'd0;
            mem_is_load <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_is_load  <= 1'b0;
        end else if (!freeze_all) begin
            wb_valid    <= mem_valid;
            wb_rd       <= mem_rd;
            wb_is_load  <= mem_is_load;
            mem_valid   <= ex_valid;
            mem_rd      <= ex_rd;
            mem_is_load <= ex_is_load;
            ex_valid    <= id_writes;
            ex_rd       <= id_rd;
            ex_is_load  <= id_writes && id_mem_read;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall_if_id || freeze_all) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush_if_id) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    // The WB entry and the FSM state are kept for observation only.
    logic debug_unused;
    assign debug_unused = ^{wb_valid, wb_rd, wb_is_load, state, (CORE != 0)};

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit.
module tb_hazard_ctrl_unit;

    localparam int AB = 20;

    logic          clock;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_uses_rs1;
    logic          id_uses_rs2;
    logic [4:0]    id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          ex_branch_taken;
    logic [AB-1:0] ex_branch_target;
    logic          mem_busy;
    logic          stall_if_id;
    logic          freeze_all;
    logic          bubble_id_ex;
    logic          flush_if_id;
    logic          redirect_valid;
    logic [AB-1:0] redirect_PC;
    logic [31:0]   stall_count;
    logic [31:0]   flush_count;

    logic [4:0]    ctl;
    int            errors;
    int            checks;

    assign ctl = {freeze_all, stall_if_id, bubble_id_ex, flush_if_id, redirect_valid};

    hazard_ctrl_unit #(.CORE(0), .ADDRESS_BITS(AB)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .mem_busy        (mem_busy),
        .stall_if_id     (stall_if_id),
        .freeze_all      (freeze_all),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .redirect_valid  (redirect_valid),
        .redirect_PC     (redirect_PC),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic idle_inputs();
        id_valid         = 1'b0;
        id_rs1           = 5'd0;
        id_rs2           = 5'd0;
        id_uses_rs1      = 1'b0;
        id_uses_rs2      = 1'b0;
        id_rd            = 5'd0;
        id_reg_write     = 1'b0;
        id_mem_read      = 1'b0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = '0;
        mem_busy         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    // Put a load (or ALU writer) to rd into ID and clock it into EX.
    task automatic writer_into_ex(input logic [4:0] rd, input logic is_load);
        idle_inputs();
        id_valid     = 1'b1;
        id_rd        = rd;
        id_reg_write = 1'b1;
        id_mem_read  = is_load;
        tick();
    endtask

    task automatic set_consumer(input logic [4:0] rs1, input logic use1,
                                input logic [4:0] rs2, input logic use2);
        idle_inputs();
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_uses_rs1  = use1;
        id_rs2       = rs2;
        id_uses_rs2  = use2;
        id_rd        = 5'd6;
        id_reg_write = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        mem_busy         = 1'b1;
        ex_branch_taken  = 1'b1;
        ex_branch_target = 20'hABCDE;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", ctl, 5'b00000);
        end
        checks++;
        if (redirect_PC !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL reset_redirect_pc: got %h expected %h", redirect_PC, 20'h00000);
        end
        tick();
        checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (ctl !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL lu_stall: got %b expected %b", ctl, 5'b01100);
        end
        tick();
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL lu_cleared: got %b expected %b", ctl, 5'b00000);
        end
        checks++;
        if (stall_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL lu_stall_count: got %0d expected 1", stall_count);
        end
        // rs2 path of the hazard comparator
        do_reset();
        writer_into_ex(5'd9, 1'b1);
        set_consumer(5'd1, 1'b1, 5'd9, 1'b1);
        #1;
        checks++;
        if (ctl !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL lu_rs2_stall: got %b expected %b", ctl, 5'b01100);
        end
        idle_inputs();
    endtask

    task automatic test_no_hazard();
        do_reset();
        writer_into_ex(5'd5, 1'b0);
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL alu_producer: got %b expected %b", ctl, 5'b00000);
        end
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        set_consumer(5'd5, 1'b0, 5'd7, 1'b1);
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL unused_source: got %b expected %b", ctl, 5'b00000);
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        writer_into_ex(5'd0, 1'b1);
        set_consumer(5'd3, 1'b0, 5'd0, 1'b1);
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL x0_no_stall: got %b expected %b", ctl, 5'b00000);
        end
        tick();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL x0_stall_count: got %0d expected 0", stall_count);
        end
        idle_inputs();
    endtask

    task automatic test_branch_load_use();
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        ex_branch_taken  = 1'b1;
        ex_branch_target = 20'h00400;
        #1;
        checks++;
        if (ctl !== 5'b00111) begin
            errors++;
            $display("[TB] FAIL br_lu_outputs: got %b expected %b", ctl, 5'b00111);
        end
        checks++;
        if (redirect_PC !== 20'h00400) begin
            errors++;
            $display("[TB] FAIL br_lu_redirect_pc: got %h expected %h", redirect_PC, 20'h00400);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (flush_count !== 32'd1 || stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL br_lu_counters: got flush=%0d stall=%0d expected flush=1 stall=0",
                     flush_count, stall_count);
        end
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL br_lu_after: got %b expected %b", ctl, 5'b00000);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL mw_freeze%0d: got %b expected %b", i, ctl, 5'b10000);
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL mw_then_stall: got %b expected %b", ctl, 5'b01100);
        end
        tick();
        checks++;
        if (stall_count !== 32'd4) begin
            errors++;
            $display("[TB] FAIL mw_stall_count: got %0d expected 4", stall_count);
        end
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL mw_done: got %b expected %b", ctl, 5'b00000);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        mem_busy = 1'b1;
        tick();
        reset            = 1'b1;
        ex_branch_taken  = 1'b1;
        ex_branch_target = 20'h12345;
        #1;
        checks++;
        if (ctl !== 5'b00000 || redirect_PC !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL rmw_in_reset: got ctl=%b pc=%h expected ctl=00000 pc=00000",
                     ctl, redirect_PC);
        end
        tick();
        reset           = 1'b0;
        mem_busy        = 1'b0;
        ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL rmw_outputs: got %b expected %b", ctl, 5'b00000);
        end
        checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rmw_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rmw_state: got %0d expected 0", dut.state);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            ex_branch_taken  = 1'b1;
            ex_branch_target = 20'h00100 + 20'(i);
            tick();
        end
        checks++;
        if (flush_count !== 32'd2) begin
            errors++;
            $display("[TB] FAIL b2b_flush_count: got %0d expected 2", flush_count);
        end
        mem_busy = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b10000 || redirect_PC !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL busy_over_branch: got ctl=%b pc=%h expected ctl=10000 pc=00000",
                     ctl, redirect_PC);
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        writer_into_ex(5'd5, 1'b1);
        force dut.stall_count = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count;
        set_consumer(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        tick();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_stall_count: got %h expected 00000000", stall_count);
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_x0();
        test_branch_load_use();
        test_mem_wait();
        test_reset_mid_wait();
        test_back_to_back();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameters: CORE, default 0, core index for multi-core instances; ADDRESS_BITS, default 20, PC width.
REQ-002 clock  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  ID source register numbers.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-007 id_rd  in  5  ID destination register.
REQ-008 id_reg_write, id_mem_read  in  1 each  ID instruction writes rd / is a load.
REQ-009 ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-010 ex_branch_target  in  ADDRESS_BITS  redirect PC from EX.
REQ-011 mem_busy  in  1  MEM stage access not complete; pipeline must freeze.
REQ-012 stall_if_id  out  1  hold PC and IF/ID register.
REQ-013 freeze_all  out  1  hold every pipeline register, including ID/EX, EX/MEM and MEM/WB.
REQ-014 bubble_id_ex  out  1  load a NOP (all control bits 0) into ID/EX.
REQ-015 flush_if_id  out  1  invalidate IF/ID contents.
REQ-016 redirect_valid, redirect_PC  out  1, ADDRESS_BITS  fetch redirect to ex_branch_target.
REQ-017 stall_count, flush_count  out  32 each  performance counters.

Function
REQ-018 The unit SHALL track writers in flight with a 3-entry scoreboard (EX, MEM, WB). Each entry holds valid, rd, is_load.
REQ-019 When not frozen, each rising edge SHALL shift the scoreboard: WB<=MEM, MEM<=EX, and EX<=ID fields.
  - EX entry valid = id_valid & id_reg_write & (id_rd!=0) & ~bubble_id_ex.
REQ-020 A load-use hazard SHALL be asserted combinationally when all of the following hold:
  - EX entry valid and is_load;
  - id_valid;
  - (id_uses_rs1 & id_rs1==EX.rd) or (id_uses_rs2 & id_rs2==EX.rd).
  Register x0 never hazards.
REQ-021 FSM states SHALL be RUN, LOAD_STALL, FLUSH, MEM_WAIT; reset state RUN.
REQ-022 Transitions, in priority order:
  - mem_busy -> MEM_WAIT;
  - else ex_branch_taken -> FLUSH;
  - else load-use -> LOAD_STALL;
  - else -> RUN.
  These are evaluated in every state.
REQ-023 Outputs SHALL be combinational from current inputs with the same priority:
  - mem_busy: freeze_all=1; all other outputs 0.
  - branch: redirect_valid=1, redirect_PC=ex_branch_target, flush_if_id=1, bubble_id_ex=1, stall_if_id=0.
  - load-use: stall_if_id=1, bubble_id_ex=1.
  - otherwise all outputs 0.
REQ-024 A load-use stall SHALL last exactly 1 cycle. After the bubble, the load sits in MEM, so the hazard clears with no second stall.
REQ-025 A branch taken in the same cycle as a load-use hazard SHALL flush only; no stall is asserted and stall_count does not increment.
REQ-026 While freeze_all=1, the scoreboard and the FSM-independent counters SHALL hold, except stall_count, which increments.
REQ-027 stall_count SHALL increment on every cycle with stall_if_id=1 or freeze_all=1. flush_count SHALL increment on every cycle with flush_if_id=1.
REQ-028 Both counters SHALL wrap from 0xFFFFFFFF to 0 silently.
REQ-029 Bubbles SHALL enter the scoreboard as invalid entries.

Reset
REQ-030 While reset=1 the unit SHALL set state=RUN, clear all scoreboard valid bits, and clear both counters.
REQ-031 While reset=1, all 1-bit outputs SHALL be driven 0 and redirect_PC SHALL be 0, regardless of other inputs.
REQ-032 Reset asserted mid-stall or mid-freeze SHALL take effect on that edge; the first post-reset cycle is RUN with an empty scoreboard.

Verification
REQ-033 Load-use: a load to x5 in EX, with the ID instruction using rs1=x5.
  - That cycle: stall_if_id=1, bubble_id_ex=1.
  - Next cycle: all 0.
  - stall_count=1.
REQ-034 x0 case: a load to x0 in EX, with ID using rs2=x0 -> no stall; stall_count remains 0.
REQ-035 Branch + load-use in the same cycle, with ex_branch_target=0x00400:
  - redirect_valid=1, redirect_PC=0x00400, flush_if_id=1, stall_if_id=0;
  - flush_count=1, stall_count=0.
REQ-036 Memory wait: mem_busy held 3 cycles during a load-use hazard.
  - freeze_all=1 for 3 cycles; the scoreboard is unchanged.
  - Then 1 load-use stall cycle follows.
  - stall_count=4.
REQ-037 Reset during MEM_WAIT: the next cycle shows state RUN, all outputs 0, and counters 0.
REQ-038 Counter wrap: preload stall_count to 0xFFFFFFFF via a forced sequence, then stall once -> stall_count=0.
